mux_8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 data mux between 8 valid/ready requesters and one downstream valid/ready sink.
- Grants one requester at a time and holds the grant until that requester's last beat or a MAX_BEATS burst cap, then re-arbitrates.
- Drives the mux select, so the data path itself stays purely combinational.

---
 rtl/mux_8_rr_arbiter_pkg.sv | 28 ++
 rtl/mux_8_rr_arbiter_if.sv | 29 ++
 rtl/mux_8_rr_arbiter_mux_8.sv | 31 +++
 rtl/mux_8_rr_arbiter.sv | 107 ++++++++++
 tb/tb_mux_8_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_8_rr_arbiter_pkg.sv
// rtl/mux_8_rr_arbiter_pkg.sv - shared constants, state encoding and round-robin pick for the 8-way arbiter
package mux_arb_pkg;

  localparam int N_REQ     = 8;
  localparam int SEL_WIDTH = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // First requesting index at or after ptr, wrapping modulo N_REQ.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [N_REQ-1:0]     req,
                                                   input logic [SEL_WIDTH-1:0] ptr);
    logic [SEL_WIDTH-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_WIDTH'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_8_rr_arbiter_if.sv
// rtl/mux_8_rr_arbiter_if.sv - requester/sink handshake bundle between the arbiter and its environment
interface mux_8_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8
) ();
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_last_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic                        m_valid_o;
  logic                        m_last_o;
  logic [DATA_WIDTH-1:0]       m_data_o;
  logic                        m_ready_i;
  logic [SEL_WIDTH-1:0]        select_o;
  logic [N_REQ-1:0]            grant_o;
  logic                        busy_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, m_ready_i,
    output req_ready_o, m_valid_o, m_last_o, m_data_o, select_o, grant_o, busy_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, m_ready_i,
    input  req_ready_o, m_valid_o, m_last_o, m_data_o, select_o, grant_o, busy_o
  );

endinterface

// File: rtl/mux_8_rr_arbiter_mux_8.sv
// rtl/mux_8_rr_arbiter_mux_8.sv - purely combinational 8:1 data mux
module mux_8 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2:0]            select_i,
  input  logic [DATA_WIDTH-1:0] data_0_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  input  logic [DATA_WIDTH-1:0] data_2_i,
  input  logic [DATA_WIDTH-1:0] data_3_i,
  input  logic [DATA_WIDTH-1:0] data_4_i,
  input  logic [DATA_WIDTH-1:0] data_5_i,
  input  logic [DATA_WIDTH-1:0] data_6_i,
  input  logic [DATA_WIDTH-1:0] data_7_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_0_i;
    case (select_i)
      3'd1:    data_o = data_1_i;
      3'd2:    data_o = data_2_i;
      3'd3:    data_o = data_3_i;
      3'd4:    data_o = data_4_i;
      3'd5:    data_o = data_5_i;
      3'd6:    data_o = data_6_i;
      3'd7:    data_o = data_7_i;
      default: data_o = data_0_i;
    endcase
  end

endmodule

// File: rtl/mux_8_rr_arbiter.sv
// rtl/mux_8_rr_arbiter.sv - round-robin packet arbiter steering one 8:1 mux to a single valid/ready sink
module mux_8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mux_8_rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'(IDLE);
  localparam logic [0:0] ST_LOCKED = 1'(LOCKED);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;

  logic locked;
  logic cur_valid;
  logic cur_last;
  logic beat;

  always_comb begin
    locked    = (state_q == ST_LOCKED);
    cur_valid = bus.req_valid_i[sel_q];
    cur_last  = bus.req_last_i[sel_q];
    beat      = locked & cur_valid & bus.m_ready_i;

    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid_i) begin
          sel_d      = rr_pick(bus.req_valid_i, ptr_q);
          grant_d    = N_REQ'(1) << sel_d;
          beat_cnt_d = 8'd0;
          state_d    = ST_LOCKED;
        end
      end
      default: begin
        // The burst cap releases without touching m_last_o; the packet resumes on a later grant.
        if (beat) begin
          if (cur_last || (beat_cnt_q == LAST_BEAT)) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            ptr_d      = sel_q + SEL_WIDTH'(1);
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.m_valid_o   = locked & cur_valid;
  assign bus.m_last_o    = locked & cur_valid & cur_last;
  assign bus.req_ready_o = (locked && bus.m_ready_i) ? (N_REQ'(1) << sel_q) : '0;
  assign bus.select_o    = sel_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = locked;

  logic [DATA_WIDTH-1:0] mux_data;

  mux_8 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux_8 (
    .select_i (sel_q),
    .data_0_i (bus.req_data_i[0*DATA_WIDTH +: DATA_WIDTH]),
    .data_1_i (bus.req_data_i[1*DATA_WIDTH +: DATA_WIDTH]),
    .data_2_i (bus.req_data_i[2*DATA_WIDTH +: DATA_WIDTH]),
    .data_3_i (bus.req_data_i[3*DATA_WIDTH +: DATA_WIDTH]),
    .data_4_i (bus.req_data_i[4*DATA_WIDTH +: DATA_WIDTH]),
    .data_5_i (bus.req_data_i[5*DATA_WIDTH +: DATA_WIDTH]),
    .data_6_i (bus.req_data_i[6*DATA_WIDTH +: DATA_WIDTH]),
    .data_7_i (bus.req_data_i[7*DATA_WIDTH +: DATA_WIDTH]),
    .data_o   (mux_data)
  );

  assign bus.m_data_o = mux_data;

endmodule

// File: tb/tb_mux_8_rr_arbiter.sv
// tb/tb_mux_8_rr_arbiter.sv - directed scoreboard bench for the round-robin mux arbiter
module tb_mux_8_rr_arbiter;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;

  mux_8_rr_arbiter_if #(.DATA_WIDTH(8)) bus ();

  mux_8_rr_arbiter #(
    .DATA_WIDTH (8),
    .MAX_BEATS  (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   rem [8];
  int   idx [8];
  bit   onebeat [8];
  exp_t sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 8; n++) begin
      bus.req_valid_i[n]         = (rem[n] > 0);
      bus.req_last_i[n]          = (rem[n] > 0) && (onebeat[n] || rem[n] == 1);
      bus.req_data_i[n*8 +: 8]   = {3'(n), 5'(idx[n])};
    end
  endtask

  task automatic load(input int n, input int len);
    rem[n] = len;
    idx[n] = 0;
  endtask

  task automatic push(input int n, input int i, input logic l);
    exp_t e;
    e.src  = n;
    e.data = {3'(n), 5'(i)};
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic clear_model();
    for (int n = 0; n < 8; n++) begin
      rem[n]     = 0;
      idx[n]     = 0;
      onebeat[n] = 1'b0;
    end
    sb.delete();
  endtask

  // Sample at the falling edge, let the handshake happen on the rising edge, then advance requesters.
  task automatic tick();
    int         hs;
    exp_t       e;
    logic [7:0] hsv;
    hs = -1;
    @(negedge clk);
    if (bus.m_valid_o && bus.m_ready_i) begin
      chk("beat_expected", 64'(sb.size() != 0), 64'd1);
      hsv = bus.req_ready_o & bus.req_valid_i;
      for (int n = 7; n >= 0; n--) if (hsv[n]) hs = n;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_src",   64'(bus.select_o),    64'(e.src));
        chk("beat_data",  64'(bus.m_data_o),    64'(e.data));
        chk("beat_last",  64'(bus.m_last_o),    64'(e.last));
        chk("beat_ready", 64'(bus.req_ready_o), 64'(8'(1) << e.src));
      end
    end
    @(posedge clk);
    #1;
    if (hs >= 0) begin
      rem[hs]--;
      idx[hs]++;
    end
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    clear_model();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_g;

  initial begin
    rst           = 1'b1;
    bus.m_ready_i = 1'b0;
    clear_model();
    idx[0] = 5;
    drive();
    #12;
    chk("rst_grant",   64'(bus.grant_o),     64'h00);
    chk("rst_select",  64'(bus.select_o),    64'd0);
    chk("rst_busy",    64'(bus.busy_o),      64'd0);
    chk("rst_mvalid",  64'(bus.m_valid_o),   64'd0);
    chk("rst_mlast",   64'(bus.m_last_o),    64'd0);
    chk("rst_ready",   64'(bus.req_ready_o), 64'h00);
    chk("rst_mdata",   64'(bus.m_data_o),    64'h05);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 3-beat request from requester 2, then pointer check.
    bus.m_ready_i = 1'b1;
    load(2, 3);
    for (int i = 0; i < 3; i++) push(2, i, i == 2);
    drive();
    tick();
    chk("t1_grant",  64'(bus.grant_o),   64'h04);
    chk("t1_select", 64'(bus.select_o),  64'd2);
    chk("t1_busy",   64'(bus.busy_o),    64'd1);
    chk("t1_mvalid", 64'(bus.m_valid_o), 64'd1);
    repeat (3) tick();
    chk("t1_idle_grant",  64'(bus.grant_o),   64'h00);
    chk("t1_idle_busy",   64'(bus.busy_o),    64'd0);
    chk("t1_idle_mvalid", 64'(bus.m_valid_o), 64'd0);
    load(4, 1);
    load(1, 1);
    push(4, 0, 1'b1);
    push(1, 0, 1'b1);
    drive();
    run_until_idle("t1_ptr", 20);

    // Fairness with all requesters valid and single-beat packets.
    reset_dut();
    for (int n = 0; n < 8; n++) begin
      load(n, 2);
      onebeat[n] = 1'b1;
    end
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 8; n++) push(n, k, 1'b1);
    drive();
    for (int t = 1; t <= 32; t++) begin
      tick();
      exp_g = (t % 2 == 1) ? (8'(1) << (((t - 1) / 2) % 8)) : 8'h00;
      chk($sformatf("t2_grant_%0d", t), 64'(bus.grant_o), 64'(exp_g));
    end
    chk("t2_drained", 64'(sb.size()), 64'd0);
    for (int n = 0; n < 8; n++) onebeat[n] = 1'b0;
    drive();

    // Pointer wrap from 6 with requesters 7, 0, 1.
    load(5, 1);
    push(5, 0, 1'b1);
    drive();
    run_until_idle("t3_pre", 10);
    load(7, 1);
    load(0, 1);
    load(1, 1);
    push(7, 0, 1'b1);
    push(0, 0, 1'b1);
    push(1, 0, 1'b1);
    drive();
    run_until_idle("t3_wrap", 20);

    // Burst cap of 4 beats with a competing requester.
    load(3, 10);
    load(4, 1);
    for (int i = 0; i < 4; i++) push(3, i, 1'b0);
    push(4, 0, 1'b1);
    for (int i = 4; i < 8; i++) push(3, i, 1'b0);
    for (int i = 8; i < 10; i++) push(3, i, i == 9);
    drive();
    run_until_idle("t4_cap", 40);

    // Backpressure on requester 1.
    load(1, 3);
    for (int i = 0; i < 3; i++) push(1, i, i == 2);
    drive();
    tick();
    for (int c = 0; c < 7; c++) begin
      bus.m_ready_i = (c % 2 == 0);
      #1;
      exp_g = (rem[1] > 0 && bus.m_ready_i) ? 8'h02 : 8'h00;
      chk($sformatf("t5_ready_%0d", c), 64'(bus.req_ready_o), 64'(exp_g));
      tick();
    end
    bus.m_ready_i = 1'b1;
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a packet.
    load(5, 4);
    for (int i = 0; i < 4; i++) push(5, i, i == 3);
    drive();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_grant",  64'(bus.grant_o),     64'h00);
    chk("t6_busy",   64'(bus.busy_o),      64'd0);
    chk("t6_mvalid", 64'(bus.m_valid_o),   64'd0);
    chk("t6_ready",  64'(bus.req_ready_o), 64'h00);
    clear_model();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    load(6, 1);
    load(1, 1);
    push(1, 0, 1'b1);
    push(6, 0, 1'b1);
    drive();
    run_until_idle("t6_after", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
